// File: rtl/ysyx_25030093_lsu.sv
// rtl/ysyx_25030093_lsu.sv - load/store unit: alignment checks, word bus access, load extension, exceptions
module ysyx_25030093_lsu #(
  parameter int TIMEOUT = 255,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_exc,
  output logic [3:0]      out_cause,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wstrb,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [XLEN-1:0] mem_resp_rdata,
  input  logic            mem_resp_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              req_wen_q, req_wen_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_load_q, is_load_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              out_wen_q, out_wen_d;
  logic              out_exc_q, out_exc_d;
  logic [3:0]        cause_q, cause_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              dec_store;
  logic              dec_illegal;
  logic              dec_misaligned;
  logic [3:0]        dec_strb;
  logic [XLEN-1:0]   dec_wdata;
  logic [XLEN-1:0]   ld_word;
  logic [XLEN-1:0]   ld_ext;

  // Classify the incoming instruction and build its store lanes; a load wins if both flags are set
  always_comb begin
    dec_store      = in_is_store && !in_is_load;
    dec_illegal    = in_is_load ? (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7)
                                : (dec_store && in_funct3 > 3'd2);
    dec_misaligned = (in_funct3[1:0] == 2'd1 && in_alu_result[0]) ||
                     (in_funct3[1:0] == 2'd2 && in_alu_result[1:0] != 2'b00);
    dec_strb       = 4'hF;
    dec_wdata      = in_wdata;
    case (in_funct3[1:0])
      2'd0: begin
        dec_strb  = 4'b0001 << in_alu_result[1:0];
        dec_wdata = {4{in_wdata[7:0]}};
      end
      2'd1: begin
        dec_strb  = 4'b0011 << {in_alu_result[1], 1'b0};
        dec_wdata = {2{in_wdata[15:0]}};
      end
      default: begin
        dec_strb  = 4'hF;
        dec_wdata = in_wdata;
      end
    endcase
  end

  // Shift the addressed lane down and extend it according to the latched size/sign
  always_comb begin
    ld_word = mem_resp_rdata >> {addr_q[1:0], 3'b000};
    ld_ext  = mem_resp_rdata;
    case (funct3_q)
      3'd0:    ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'd1:    ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'd4:    ld_ext = {24'b0, ld_word[7:0]};
      3'd5:    ld_ext = {16'b0, ld_word[15:0]};
      default: ld_ext = mem_resp_rdata;
    endcase
  end

  // Next-state and holding-register update for the IDLE/REQ/RESP/DONE sequence
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    req_wen_d  = req_wen_q;
    funct3_d   = funct3_q;
    is_load_d  = is_load_q;
    rd_d       = rd_q;
    out_data_d = out_data_q;
    out_wen_d  = out_wen_q;
    out_exc_d  = out_exc_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d     = in_alu_result;
          wdata_d    = dec_wdata;
          wstrb_d    = dec_store ? dec_strb : 4'b0000;
          req_wen_d  = dec_store;
          funct3_d   = in_funct3;
          is_load_d  = in_is_load;
          rd_d       = in_rd;
          out_data_d = '0;
          out_wen_d  = 1'b0;
          out_exc_d  = 1'b0;
          cause_d    = 4'd0;
          cnt_d      = '0;
          if (!in_is_load && !in_is_store) begin
            out_data_d = in_alu_result;
            out_wen_d  = in_wen;
            state_d    = DONE;
          end else if (dec_illegal) begin
            out_exc_d = 1'b1;
            cause_d   = 4'd2;
            state_d   = DONE;
          end else if (dec_misaligned) begin
            out_exc_d = 1'b1;
            cause_d   = in_is_load ? 4'd4 : 4'd6;
            state_d   = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Any response to a request accepted on this very cycle is dropped later as a late response
          out_exc_d = 1'b1;
          cause_d   = is_load_q ? 4'd5 : 4'd7;
          state_d   = DONE;
        end else if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_resp_valid) begin
          state_d = DONE;
          if (mem_resp_err) begin
            out_exc_d = 1'b1;
            cause_d   = is_load_q ? 4'd5 : 4'd7;
          end else if (is_load_q) begin
            out_data_d = ld_ext;
            out_wen_d  = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          out_exc_d = 1'b1;
          cause_d   = is_load_q ? 4'd5 : 4'd7;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      req_wen_q  <= 1'b0;
      funct3_q   <= 3'd0;
      is_load_q  <= 1'b0;
      rd_q       <= 5'd0;
      out_data_q <= '0;
      out_wen_q  <= 1'b0;
      out_exc_q  <= 1'b0;
      cause_q    <= 4'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      req_wen_q  <= req_wen_d;
      funct3_q   <= funct3_d;
      is_load_q  <= is_load_d;
      rd_q       <= rd_d;
      out_data_q <= out_data_d;
      out_wen_q  <= out_wen_d;
      out_exc_q  <= out_exc_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign mem_req_valid  = (state_q == REQ);
  assign mem_resp_ready = (state_q != REQ);
  assign mem_req_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign mem_req_wen    = req_wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;
  assign out_data       = out_data_q;
  assign out_rd         = rd_q;
  assign out_wen        = out_wen_q;
  assign out_exc        = out_exc_q;
  assign out_cause      = cause_q;

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// tb/tb_ysyx_25030093_lsu.sv - directed and randomized bench for ysyx_25030093_lsu against a reference model
module tb_ysyx_25030093_lsu;

  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_alu_result, in_wdata;
  logic [2:0]  in_funct3;
  logic        in_is_load, in_is_store;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen, out_exc;
  logic [3:0]  out_cause;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  ysyx_25030093_lsu #(.TIMEOUT(TMO), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_result(in_alu_result), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wen(out_wen), .out_exc(out_exc), .out_cause(out_cause),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        owen;
    logic        exc;
    logic [3:0]  cause;
    logic        chk_data;
    logic [7:0]  lat;
  } exp_t;

  int n_cmp;
  int n_fail;

  logic        o_req, o_wen, o_owen, o_exc;
  logic [31:0] o_addr, o_wdata, o_data;
  logic [3:0]  o_wstrb, o_cause;
  logic [4:0]  o_rd;
  int          o_lat;
  logic        req_stable, out_stable, busy_ok, rr_ok, drop_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outcome computed from the architectural rules for one instruction
  function automatic exp_t model(input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] f3,
                                 input logic ld, input logic st, input logic wen,
                                 input logic [31:0] rdata, input logic err, input logic tmo,
                                 input int rq_w, input int rs_w);
    exp_t        e;
    int          f, size, off;
    logic [31:0] mask, v;
    e   = '0;
    f   = int'(f3);
    off = int'(alu % 32'd4);
    if (!ld && !st) begin
      e.data = alu; e.owen = wen; e.chk_data = 1'b1; e.lat = 8'd1;
      return e;
    end
    if ((ld && (f == 3 || f >= 6)) || (!ld && f > 2)) begin
      e.exc = 1'b1; e.cause = 4'd2; e.lat = 8'd1;
      return e;
    end
    size = 1 << (f % 4);
    if (off % size != 0) begin
      e.exc = 1'b1; e.cause = ld ? 4'd4 : 4'd6; e.lat = 8'd1;
      return e;
    end
    mask    = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    e.req   = 1'b1;
    e.addr  = alu - 32'(off);
    e.wen   = !ld;
    e.wstrb = ld ? 4'd0 : 4'(((1 << size) - 1) << off);
    e.wdata = (wd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1);
    if (tmo) begin
      e.exc = 1'b1; e.cause = ld ? 4'd5 : 4'd7; e.lat = 8'(TMO + 1);
      return e;
    end
    e.lat = 8'(3 + rq_w + rs_w);
    if (err) begin
      e.exc = 1'b1; e.cause = ld ? 4'd5 : 4'd7;
    end else if (ld) begin
      v = (rdata >> (8 * off)) & mask;
      if (f < 4 && size < 4 && v > (mask >> 1)) v = v | ~mask;
      e.data = v; e.owen = 1'b1; e.chk_data = 1'b1;
    end
    return e;
  endfunction

  // Issue one instruction, play the memory side with the given waits, and record what the DUT did
  task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] f3,
                        input logic ld, input logic st, input logic [4:0] rd, input logic wen,
                        input logic [31:0] rdata, input logic err,
                        input int rq_w, input int rs_w, input int out_w);
    int cyc, rw, rc, ow;
    bit fired, sent, got, done;
    o_req = 1'b0; o_addr = 'x; o_wen = 1'bx; o_wdata = 'x; o_wstrb = 'x;
    o_data = 'x; o_owen = 1'bx; o_exc = 1'bx; o_cause = 'x; o_rd = 'x; o_lat = 0;
    req_stable = 1'b1; out_stable = 1'b1; busy_ok = 1'b1; rr_ok = 1'b1; drop_ok = 1'b1;
    cyc = 0; rw = 0; rc = 0; ow = 0; fired = 0; sent = 0; got = 0; done = 0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_alu_result = alu; in_wdata = wd; in_funct3 = f3;
    in_is_load = ld; in_is_store = st; in_rd = rd; in_wen = wen;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        in_valid = 1'b0; in_alu_result = $urandom; in_wdata = $urandom; in_funct3 = 3'($urandom);
        in_is_load = 1'($urandom); in_is_store = 1'($urandom); in_rd = 5'($urandom); in_wen = 1'($urandom);
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_rdata = $urandom;
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) begin
        if (mem_req_valid) drop_ok = 1'b0;
        if (!got) begin
          got = 1; o_lat = cyc;
          o_data = out_data; o_rd = out_rd; o_owen = out_wen; o_exc = out_exc; o_cause = out_cause;
        end else if (out_data !== o_data || out_rd !== o_rd || out_wen !== o_owen ||
                     out_exc !== o_exc || out_cause !== o_cause) begin
          out_stable = 1'b0;
        end
        if (ow >= out_w) begin
          out_ready = 1'b1; done = 1;
        end
        ow++;
      end else if (mem_req_valid) begin
        if (mem_resp_ready) rr_ok = 1'b0;
        if (!o_req) begin
          o_req = 1'b1; o_addr = mem_req_addr; o_wen = mem_req_wen;
          o_wdata = mem_req_wdata; o_wstrb = mem_req_wstrb;
        end else if (mem_req_addr !== o_addr || mem_req_wen !== o_wen ||
                     mem_req_wdata !== o_wdata || mem_req_wstrb !== o_wstrb) begin
          req_stable = 1'b0;
        end
        if (rw >= rq_w) begin
          mem_req_ready = 1'b1; fired = 1;
        end
        rw++;
      end else if (fired && !sent) begin
        if (rc >= rs_w) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_resp_err = err; sent = 1;
        end
        rc++;
      end
    end
    check("op_completes", 32'(done), 1);
    @(negedge clk);
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check("exit_to_idle", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic check_op(input exp_t e, input logic [4:0] rd);
    check("latency", o_lat, 32'(e.lat));
    check("req_issued", o_req, e.req);
    if (e.req) begin
      check("req_addr", o_addr, e.addr);
      check("req_wen", o_wen, e.wen);
      check("req_wstrb", o_wstrb, e.wstrb);
      if (e.wen) check("req_wdata", o_wdata, e.wdata);
      check("req_stable", req_stable, 1);
      check("resp_ready_low_in_req", rr_ok, 1);
    end
    check("out_exc", o_exc, e.exc);
    check("out_cause", o_cause, e.cause);
    check("out_wen", o_owen, e.owen);
    check("out_rd", o_rd, rd);
    if (e.chk_data) check("out_data", o_data, e.data);
    check("out_stable", out_stable, 1);
    check("in_ready_low_busy", busy_ok, 1);
    check("req_dropped_in_done", drop_ok, 1);
  endtask

  exp_t        e;
  logic [31:0] r_alu, r_wd, r_rdata;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_ld, r_st, r_wen, r_err, quiet;
  int          kind, r_rq, r_rs, r_ow;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_wdata = '0; in_funct3 = '0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_rd = '0; in_wen = 1'b0; out_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_handshake", {in_ready, mem_resp_ready, out_valid, mem_req_valid}, 4'b1100);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_req_wdata", mem_req_wdata, 0);
    check("rst_req_ctrl", {mem_req_wen, mem_req_wstrb}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", {out_rd, out_wen, out_exc, out_cause}, 0);
    rst = 1'b1;

    // non-memory pass-through
    run_op(32'h1234, 32'h0, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h0, 1'b0, 0, 0, 0);
    check_op(model(32'h1234, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 0), 5'd5);
    check("nonmem_data", o_data, 32'h1234);

    // lb / lbu from the top byte
    run_op(32'h8000_0003, 32'h0, 3'd0, 1'b1, 1'b0, 5'd7, 1'b0, 32'h80FF_FF12, 1'b0, 0, 0, 0);
    check_op(model(32'h8000_0003, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h80FF_FF12, 1'b0, 1'b0, 0, 0), 5'd7);
    check("lb_addr", o_addr, 32'h8000_0000);
    check("lb_data", o_data, 32'hFFFF_FF80);
    run_op(32'h8000_0003, 32'h0, 3'd4, 1'b1, 1'b0, 5'd8, 1'b0, 32'h80FF_FF12, 1'b0, 0, 0, 0);
    check_op(model(32'h8000_0003, 32'h0, 3'd4, 1'b1, 1'b0, 1'b0, 32'h80FF_FF12, 1'b0, 1'b0, 0, 0), 5'd8);
    check("lbu_data", o_data, 32'h0000_0080);

    // sh to the upper half
    run_op(32'h8000_0002, 32'hAAAA_BEEF, 3'd1, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    check_op(model(32'h8000_0002, 32'hAAAA_BEEF, 3'd1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0), 5'd9);
    check("sh_wstrb", o_wstrb, 4'b1100);
    check("sh_wdata", o_wdata, 32'hBEEF_BEEF);

    // misaligned and illegal-size accesses never reach the bus
    run_op(32'h8000_0001, 32'h0, 3'd2, 1'b1, 1'b0, 5'd10, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    check_op(model(32'h8000_0001, 32'h0, 3'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0), 5'd10);
    check("lw_mis_cause", o_cause, 4'd4);
    run_op(32'h8000_0006, 32'h1, 3'd2, 1'b0, 1'b1, 5'd11, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    check_op(model(32'h8000_0006, 32'h1, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0), 5'd11);
    check("sw_mis_cause", o_cause, 4'd6);
    run_op(32'h8000_0000, 32'h0, 3'd3, 1'b1, 1'b0, 5'd12, 1'b1, 32'h0, 1'b0, 0, 0, 0);
    check_op(model(32'h8000_0000, 32'h0, 3'd3, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 0), 5'd12);
    run_op(32'h8000_0000, 32'h0, 3'd4, 1'b0, 1'b1, 5'd13, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    check_op(model(32'h8000_0000, 32'h0, 3'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0), 5'd13);

    // backpressure on both sides, bus error on a load, then a clean backpressured store
    run_op(32'h8000_0010, 32'h0, 3'd2, 1'b1, 1'b0, 5'd14, 1'b0, 32'hCAFE_F00D, 1'b1, 5, 0, 3);
    check_op(model(32'h8000_0010, 32'h0, 3'd2, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 5, 0), 5'd14);
    check("err_cause", o_cause, 4'd5);
    run_op(32'h8000_0021, 32'h1234_5678, 3'd0, 1'b0, 1'b1, 5'd15, 1'b0, 32'h0, 1'b0, 5, 1, 3);
    check_op(model(32'h8000_0021, 32'h1234_5678, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5, 1), 5'd15);

    // timeout with no response, followed by a late response that must be swallowed
    run_op(32'h8000_0040, 32'h0, 3'd2, 1'b1, 1'b0, 5'd16, 1'b0, 32'h0, 1'b0, 0, NEVER, 0);
    check_op(model(32'h8000_0040, 32'h0, 3'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0, 0), 5'd16);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    check("late_resp_ready", mem_resp_ready, 1);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    check("late_resp_discarded", quiet, 1);
    // timeout while the request is never accepted
    run_op(32'h8000_0044, 32'h55, 3'd2, 1'b0, 1'b1, 5'd17, 1'b0, 32'h0, 1'b0, NEVER, 0, 1);
    check_op(model(32'h8000_0044, 32'h55, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 0, 0), 5'd17);

    // reset asserted while waiting for a response
    @(negedge clk);
    in_valid = 1'b1; in_alu_result = 32'h8000_0080; in_funct3 = 3'd2; in_is_load = 1'b1; in_is_store = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_test_in_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rst_test_in_resp", {mem_req_valid, mem_resp_ready, in_ready, out_valid}, 4'b0100);
    #2 rst = 1'b0;
    #1 check("rst_async_idle", {in_ready, mem_resp_ready, out_valid, mem_req_valid}, 4'b1100);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    check("rst_no_output", quiet, 1);

    // randomized mix
    for (int i = 0; i < 120; i++) begin
      kind  = $urandom_range(0, 2);
      r_ld  = (kind == 1);
      r_st  = (kind == 2);
      r_alu = (kind == 0) ? $urandom : (32'h8000_0000 | ($urandom & 32'h0000_0FFF));
      r_wd  = $urandom;
      r_f3  = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        r_f3 = 3'($urandom_range(0, 2));
        if (r_ld && r_f3 != 3'd2 && $urandom_range(0, 1) == 1) r_f3 = r_f3 + 3'd4;
      end
      r_rd    = 5'($urandom);
      r_wen   = 1'($urandom);
      r_rdata = $urandom;
      r_err   = ($urandom_range(0, 7) == 0);
      r_rq    = $urandom_range(0, 2);
      r_rs    = $urandom_range(0, 2);
      r_ow    = $urandom_range(0, 2);
      run_op(r_alu, r_wd, r_f3, r_ld, r_st, r_rd, r_wen, r_rdata, r_err, r_rq, r_rs, r_ow);
      e = model(r_alu, r_wd, r_f3, r_ld, r_st, r_wen, r_rdata, r_err, 1'b0, r_rq, r_rs);
      check_op(e, r_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_lsu.md
Name: ysyx_25030093_lsu

Overview:
Load/store unit sitting directly downstream of the ALU and upstream of register write-back. It accepts one executed instruction per valid/ready handshake. For memory ops, it issues a word-aligned request on a split request/response memory bus and aligns and extends load data. It reports misalignment, bus errors and timeouts as exceptions, and passes non-memory results through unchanged.

Parameters:
TIMEOUT, 255, cycles spent in REQ+RESP before the access is aborted with an access fault
XLEN, 32, data/address width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  ALU result valid
in_ready  out  1  LSU can accept
in_alu_result  in  32  effective address (mem op) or ALU result (non-mem)
in_wdata  in  32  store data (rs2)
in_funct3  in  3  size/sign: 0 b, 1 h, 2 w, 4 bu, 5 hu
in_is_load  in  1  load instruction
in_is_store  in  1  store instruction
in_rd  in  5  destination register
in_wen  in  1  non-mem op writes rd
out_valid  out  1  result valid to write-back
out_ready  in  1  write-back accepts
out_data  out  32  rd write data
out_rd  out  5  destination register
out_wen  out  1  write rd
out_exc  out  1  exception flag
out_cause  out  4  4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault, 2 illegal size
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  {addr[31:2],2'b00}
mem_req_wen  out  1  1 store, 0 load
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte enables (0 for loads)
mem_resp_valid  in  1  response valid
mem_resp_ready  out  1  LSU accepts response
mem_resp_rdata  in  32  load word
mem_resp_err  in  1  bus error

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except in_ready=1 and mem_resp_ready=1. Timeout counter 0. Reset mid-access abandons the access with no output.
- States: IDLE, REQ, RESP, DONE. All outputs are registered or decoded from state and holding regs only, with no combinational in->out path.
- IDLE: in_ready=1. On in_valid, latch all inputs.
  - Neither load nor store: DONE, out_data=in_alu_result, out_wen=in_wen, out_exc=0.
  - Load with funct3 in {3,6,7}, or store with funct3>2: DONE, exc=1, cause=2, out_wen=0.
  - Misaligned (h/hu with addr[0]=1, w with addr[1:0]!=0): DONE, exc=1, cause 4 (load) or 6 (store), out_wen=0, no bus request.
  - Otherwise: REQ.
- REQ: mem_req_valid=1, with addr, wen, wdata and wstrb stable until mem_req_ready is sampled high, then RESP.
  - sb: wstrb=4'b0001<<addr[1:0], wdata={4{b}}.
  - sh: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{h}}.
  - sw: wstrb=4'hF.
- RESP: mem_resp_ready=1. On mem_resp_valid, go to DONE.
  - err=1: exc=1, cause 5 (load) or 7 (store), out_wen=0.
  - Load ok: out_wen=1, out_data = selected byte/half (by addr[1:0]/addr[1]), sign-extended for 0/1 and zero-extended for 4/5.
  - Store ok: out_wen=0, exc=0.
- Timeout: counter clears on entering REQ and increments each cycle in REQ/RESP. When count==TIMEOUT-1 without completing, go to DONE with fault cause 5/7 and drop mem_req_valid. Late responses arriving in IDLE/DONE are accepted (mem_resp_ready=1) and discarded. mem_resp_ready=0 in REQ.
- DONE: out_valid=1 and all out_* held stable until out_ready, then IDLE. in_ready=0 outside IDLE.
- Latency from accept, with zero-wait memory: non-mem/exception 1 cycle to out_valid; memory op 3 cycles (REQ, RESP, DONE). Throughput is one instruction per (latency+1) cycles.
- out_wen is never 1 when out_exc=1. rd=x0 writes are passed through; the register file ignores them.

Test Plan:
- Non-mem pass-through: alu_result=0x1234, wen=1, rd=5 -> out_valid 1 cycle later, data=0x1234, rd=5, wen=1, no mem_req_valid.
- lb at 0x80000003, resp_rdata=0x80FF_FF12 -> req_addr=0x80000000, wstrb=0. out_data=0xFFFFFF80, wen=1. Repeat with lbu -> 0x00000080.
- sh at 0x80000002, wdata=0xAAAA_BEEF -> wstrb=4'b1100, req_wdata=0xBEEFBEEF, out_wen=0, exc=0.
- lw at 0x80000001 -> no request, out_exc=1, cause=4. sw at 0x80000006 -> cause=6.
- Backpressure: mem_req_ready low 5 cycles and out_ready low 3 cycles -> request fields and out_* stable throughout, in_ready=0 until the handshake completes. resp_err=1 on a load -> cause=5, wen=0.
- Timeout: TIMEOUT=8, memory never responds -> out_exc=1, cause=5 after 8 cycles in REQ/RESP. A late response 2 cycles later is consumed with no second out_valid. Assert rst low in RESP -> state returns to IDLE immediately.
